// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C slave engine.
//   i2c_state_e : engine FSM states
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//   BITCNT_W : width of the per-byte bit counter
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic        I2C_ACK  = 1'b0;
  localparam logic        I2C_NACK = 1'b1;
  localparam int unsigned BITCNT_W = 3;

endpackage

// File: rtl/i2c_slave_core_if.sv
// i2c_slave_core_if: pad and register-side signals of the I2C slave engine.
//   scl_i, sda_i : asynchronous pad inputs
//   sda_oe       : 1 = pull SDA low
//   rx_data/rx_valid : received write byte + one-cycle strobe
//   tx_req/tx_data   : read byte request strobe + byte (sampled 1 clk later)
//   rw, busy, start_det, stop_det : transfer status
// Modports: slave (the engine), master (pad model / register file side).
interface i2c_slave_core_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       rw;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: STAGES-deep synchronizer for an asynchronous pad input,
// followed by one compare register producing single-cycle edge pulses.
//   clk, reset : system clock, async active-high reset (chain resets to 1)
//   d_i        : asynchronous input
//   level_o    : synchronized level
//   rise_o     : one-cycle pulse on 0->1
//   fall_o     : one-cycle pulse on 1->0
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              cmp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cmp_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      cmp_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~cmp_q;
  assign fall_o  = ~sync_q[STAGES-1] & cmp_q;

endmodule

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C slave bit/byte engine running entirely on clk.
// Oversamples SCL/SDA, detects START/STOP, matches SLAVE_ADDR, delivers
// write bytes on rx_valid and fetches read bytes through tx_req.
//   clk, reset : system clock (>= 16x SCL), async active-high reset
//   bus        : i2c_slave_core_if.slave (pads + register-side handshake)
module i2c_slave_core #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  i2c_slave_core_if.slave         bus
);
  import i2c_pkg::*;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .d_i(bus.scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .d_i(bus.sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // An SCL edge in the same cycle wins; the SDA change is then data, not a condition.
  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_cond  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

  i2c_state_e          state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                done_q, done_d;      // 8 bits shifted in, waiting for the closing scl_fall
  logic                sda_oe_q, sda_oe_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_req_q, tx_req_d;
  logic                rw_q, rw_d;
  logic                busy_q, busy_d;
  logic                start_q, stop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      start_q    <= start_cond;
      stop_q     <= stop_cond;
    end
  end

  // sda_oe_d only moves on scl_fall cycles (or START/STOP), so the pad
  // changes one clk after the falling edge is seen and never near a rise.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    // Read byte is captured the cycle after its request.
    if (tx_req_q) shift_d = bus.tx_data;

    if (start_cond) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_cond) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
            if (bitcnt_q == '1) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = ~I2C_ACK;
                rw_d     = shift_q[0];
                busy_d   = 1'b1;
                tx_req_d = shift_q[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = ST_WR_ACK;
              sda_oe_d   = ~I2C_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              sda_oe_d = ~shift_q[7];
            end else begin
              state_d  = ST_WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        ST_RD_DATA: begin
          // Counting on scl_fall: bit 7 is already on the pad on entry.
          if (scl_fall) begin
            if (bitcnt_q == '1) begin
              state_d  = ST_RD_ACK;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              bitcnt_d = bitcnt_q + BITCNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) state_d = ST_IGNORE;
            else                     tx_req_d = 1'b1;
          end else if (scl_fall) begin
            state_d  = ST_RD_DATA;
            sda_oe_d = ~shift_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.rw        = rw_q;
  assign bus.busy      = busy_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: directed bus-master bench for i2c_slave_core.
`timescale 1ns/1ps
module tb_i2c_slave_core;
  import i2c_pkg::*;

  localparam time Q = 50;  // quarter SCL period (SCL = 200 ns, clk = 10 ns)

  logic clk;
  logic reset;
  logic m_scl;
  logic m_sda;
  logic sda_line;

  int checks   = 0;
  int failures = 0;

  i2c_slave_core_if bus();

  assign sda_line  = m_sda & ~bus.sda_oe;
  assign bus.scl_i = m_scl;
  assign bus.sda_i = sda_line;

  i2c_slave_core #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitors (cumulative; the stimulus takes snapshots)
  int         rxv_cnt = 0;
  int         txr_cnt = 0;
  int         st_cnt  = 0;
  int         sp_cnt  = 0;
  int         oe_cnt  = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid)  begin rxv_cnt++; last_rx = bus.rx_data; end
      if (bus.tx_req)    txr_cnt++;
      if (bus.start_det) st_cnt++;
      if (bus.stop_det)  sp_cnt++;
      if (bus.sda_oe)    oe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    #Q m_sda = b;
    #Q m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
  endtask

  task automatic scl_bit(input logic b, output logic obs);
    #Q m_sda = b;
    #Q m_scl = 1'b1;
    #Q obs = sda_line;
    #Q m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) drive_bit(b[i]);
    scl_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic o;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      scl_bit(1'b1, o);
      b = {b[6:0], o};
    end
    drive_bit(mack);
  endtask

  task automatic start_idle();
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
  endtask

  task automatic start_rep();
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  initial begin
    logic       a0, a1, a2, o;
    logic [7:0] b0, b1;
    int         rx0, tx0, st0, sp0, oe0;

    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; bus.tx_data = 8'h00;
    #100 reset = 1'b0;
    #100;

    // Reset state
    chk("rst_sda_oe",   32'(bus.sda_oe),    32'h0);
    chk("rst_rx_data",  32'(bus.rx_data),   32'h00);
    chk("rst_rx_valid", 32'(bus.rx_valid),  32'h0);
    chk("rst_tx_req",   32'(bus.tx_req),    32'h0);
    chk("rst_rw",       32'(bus.rw),        32'h0);
    chk("rst_busy",     32'(bus.busy),      32'h0);
    chk("rst_start",    32'(bus.start_det), 32'h0);
    chk("rst_stop",     32'(bus.stop_det),  32'h0);
    chk("rst_state",    32'(dut.state_q),   32'(ST_IDLE));

    // Write two bytes
    rx0 = rxv_cnt; st0 = st_cnt; sp0 = sp_cnt;
    start_idle();
    send_byte(8'h84, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    chk("wr_ack_addr", 32'(a0), 32'h0);
    chk("wr_ack_b0",   32'(a1), 32'h0);
    chk("wr_ack_b1",   32'(a2), 32'h0);
    chk("wr_busy",     32'(bus.busy), 32'h1);
    chk("wr_rw",       32'(bus.rw),   32'h0);
    stop_cond();
    #200;
    chk("wr_rxv_cnt",  32'(rxv_cnt - rx0), 32'd2);
    chk("wr_rx_last",  32'(last_rx),       32'h3C);
    chk("wr_rx_data",  32'(bus.rx_data),   32'h3C);
    chk("wr_start",    32'(st_cnt - st0),  32'd1);
    chk("wr_stop",     32'(sp_cnt - sp0),  32'd1);
    chk("wr_busy_end", 32'(bus.busy),      32'h0);

    // Read two bytes, master ACK then NACK
    tx0 = txr_cnt;
    bus.tx_data = 8'h81;
    start_idle();
    send_byte(8'h85, a0);
    chk("rd_ack_addr", 32'(a0), 32'h0);
    chk("rd_rw",       32'(bus.rw), 32'h1);
    bus.tx_data = 8'h7E;
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    chk("rd_byte0",    32'(b0), 32'h81);
    chk("rd_byte1",    32'(b1), 32'h7E);
    chk("rd_txreq",    32'(txr_cnt - tx0), 32'd2);
    chk("rd_oe_nack",  32'(bus.sda_oe), 32'h0);
    chk("rd_state",    32'(dut.state_q), 32'(ST_IGNORE));
    stop_cond();
    #200;
    chk("rd_busy_end", 32'(bus.busy), 32'h0);

    // Address mismatch
    rx0 = rxv_cnt; oe0 = oe_cnt;
    start_idle();
    send_byte(8'h86, a0);
    chk("mm_nack_addr", 32'(a0), 32'h1);
    chk("mm_state0",    32'(dut.state_q), 32'(ST_IGNORE));
    send_byte(8'hFF, a1);
    chk("mm_nack_data", 32'(a1), 32'h1);
    chk("mm_state1",    32'(dut.state_q), 32'(ST_IGNORE));
    chk("mm_oe_cnt",    32'(oe_cnt - oe0), 32'd0);
    chk("mm_rxv",       32'(rxv_cnt - rx0), 32'd0);
    chk("mm_busy",      32'(bus.busy), 32'h0);
    stop_cond();
    #200;
    chk("mm_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Repeated START: write then read
    rx0 = rxv_cnt; st0 = st_cnt; tx0 = txr_cnt;
    start_idle();
    send_byte(8'h84, a0);
    send_byte(8'h10, a1);
    chk("rs_ack_addr", 32'(a0), 32'h0);
    chk("rs_ack_data", 32'(a1), 32'h0);
    chk("rs_rw0",      32'(bus.rw), 32'h0);
    bus.tx_data = 8'h55;
    start_rep();
    send_byte(8'h85, a2);
    chk("rs_ack_addr2", 32'(a2), 32'h0);
    chk("rs_rw1",       32'(bus.rw), 32'h1);
    chk("rs_start",     32'(st_cnt - st0), 32'd2);
    chk("rs_rxv",       32'(rxv_cnt - rx0), 32'd1);
    chk("rs_rx_last",   32'(last_rx), 32'h10);
    chk("rs_txreq",     32'(txr_cnt - tx0), 32'd1);
    recv_byte(1'b1, b0);
    chk("rs_rd_byte",   32'(b0), 32'h55);
    stop_cond();
    #200;

    // Reset during bit 4 of a read byte
    bus.tx_data = 8'h00;
    start_idle();
    send_byte(8'h85, a0);
    chk("rr_ack_addr", 32'(a0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      scl_bit(1'b1, o);
      chk("rr_bit_low", 32'(o), 32'h0);
    end
    #Q;
    chk("rr_oe_before", 32'(bus.sda_oe), 32'h1);
    reset = 1'b1;
    #2;
    chk("rr_oe_async",  32'(bus.sda_oe), 32'h0);
    #8;
    m_scl = 1'b1; m_sda = 1'b1;
    #50 reset = 1'b0;
    #200;
    chk("rr_busy",      32'(bus.busy), 32'h0);
    start_idle();
    send_byte(8'h84, a1);
    chk("rr_ack_after", 32'(a1), 32'h0);
    stop_cond();
    #200;

    // Aborted byte: START after 4 data bits
    rx0 = rxv_cnt; st0 = st_cnt;
    start_idle();
    send_byte(8'h84, a0);
    chk("ab_ack_addr", 32'(a0), 32'h0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    bus.tx_data = 8'hFF;
    start_rep();
    chk("ab_state",    32'(dut.state_q), 32'(ST_ADDR));
    chk("ab_start",    32'(st_cnt - st0), 32'd2);
    send_byte(8'h85, a1);
    chk("ab_ack_addr2", 32'(a1), 32'h0);
    chk("ab_rw",        32'(bus.rw), 32'h1);
    chk("ab_busy",      32'(bus.busy), 32'h1);
    recv_byte(1'b1, b1);
    chk("ab_rd_byte",   32'(b1), 32'hFF);
    stop_cond();
    #200;
    chk("ab_rxv",       32'(rxv_cnt - rx0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
